mem_rdata_router: RTL
=====================

// Module: mem_rdata_router
// PURPOSE
//  Registered successor to the RAM-output steering mux of the multi-cycle core.
//  Captures memory read data into an internal instruction register (fetch) or
//  read-data register (load) under a request/valid handshake with wait states.
//  Supports sub-word loads with sign/zero extension and a wait-state timeout.
//  Sits between the RAM read port and the IR / read register of the datapath.
// PARAMETERS
//  DATA_W   16  RAM word / instruction width (even, >=16)
//  TMO_W    4   width of the wait-state counter; timeout after 2**TMO_W-1 waits
//  TMO_EN   1   1: timeout enabled; 0: wait for mem_valid indefinitely
// PORTS
//  clk        in   1       system clock, all state on rising edge
//  rst_n      in   1       synchronous active-low reset
//  fetch_req  in   1       pulse: start instruction fetch (ignored unless IDLE)
//  load_req   in   1       pulse: start data load (ignored unless IDLE)
//  ld_mode    in   2       00 word, 01 byte unsigned, 10 byte signed, 11 rsvd=word
//  ld_hi      in   1       byte select for byte loads: 1 upper byte, 0 lower
//  mem_rd     out  1       read strobe to RAM, high in FETCH_W/LOAD_W
//  mem_valid  in   1       ram_out holds valid data this cycle
//  ram_out    in   DATA_W  RAM read data
//  ir_out     out  DATA_W  instruction register (held across loads)
//  rd_out     out  DATA_W  read-data register, extended per ld_mode
//  busy       out  1       high while not IDLE; core stalls phase advance
//  done       out  1       one-cycle pulse when a capture completes
//  tmo_err    out  1       sticky; set on timeout, cleared by reset or new req
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state IDLE, ir_out=0, rd_out=0, mem_rd=0,
//    busy=0, done=0, tmo_err=0, wait counter=0. Reset wins over all inputs.
//  - FSM states: IDLE, FETCH_W, LOAD_W.
//    IDLE: fetch_req -> FETCH_W; else load_req -> LOAD_W; both high -> fetch
//      wins, load dropped. Accepting any req clears tmo_err and the counter.
//      ld_mode/ld_hi latched on load acceptance.
//    FETCH_W: mem_valid -> ir_out<=ram_out, done=1 next cycle, -> IDLE.
//    LOAD_W: mem_valid -> rd_out<=extend(ram_out), ir_out unchanged, done=1,
//      -> IDLE.
//  - Latency: req at edge N, mem_rd high from N+1; mem_valid sampled at edge
//    M>=N+1 -> register updated and done high in cycle after M. Zero wait:
//    req-to-done = 2 cycles. Back-to-back: new req accepted in done cycle.
//  - mem_valid in IDLE ignored; registers hold.
//  - Extension: word -> ram_out; byte -> selected byte in [7:0]; upper bits
//    zero (01) or copies of byte bit 7 (10).
//  - Timeout (TMO_EN=1): counter increments each W-state cycle without
//    mem_valid; at all-ones with no mem_valid -> tmo_err=1, -> IDLE, target
//    register unchanged, no done. mem_valid in that same cycle wins (no error).
//  - Counter saturates, never wraps. Req pulses while busy are ignored.
// STRUCTURE
//  - Shared pkg (core_pkg): state encoding localparams, LD_WORD/LD_BU/LD_BS
//    codes, DATA_W default shared with datapath.
//  - One sub-module: ld_extend (combinational, DATA_W param) for byte
//    select/extension; FSM, counter and registers stay in this module.
// TESTING
//  1 Reset: drive all inputs high, rst_n=0 one edge -> all outputs 0, IDLE.
//  2 Fetch, 0 waits: fetch_req, mem_valid=1 with ram_out=16'hA5C3 -> ir_out=A5C3,
//    done pulse 2 cycles after req, rd_out unchanged.
//  3 Load byte signed hi, 3 waits: ram_out=16'h80FF, ld_mode=10, ld_hi=1 ->
//    rd_out=16'hFF80, ir_out unchanged, busy high 4 cycles.
//  4 Load byte unsigned lo: ram_out=16'h80FF, ld_mode=01, ld_hi=0 -> rd_out=00FF.
//  5 Timeout: TMO_W=4, load_req, mem_valid=0 -> tmo_err at 15th wait, IDLE,
//    rd_out unchanged; next fetch_req clears tmo_err.
//  6 Simultaneous fetch_req+load_req -> fetch only; rst_n low mid-LOAD_W ->
//    IDLE, rd_out=0, later mem_valid ignored.

Source files
------------

// File: rtl/mem_rdata_router_pkg.sv
// Shared definitions for the RAM read-data router: FSM states, load-mode
// codes and the default datapath word width.
package mem_rdata_router_pkg;

  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH_W = 2'd1,
    ST_LOAD_W  = 2'd2
  } state_e;

  // Load-mode codes; 2'b11 is reserved and behaves as a word load.
  localparam logic [1:0] LD_WORD = 2'b00;
  localparam logic [1:0] LD_BU   = 2'b01;
  localparam logic [1:0] LD_BS   = 2'b10;

endpackage

// File: rtl/mem_rdata_router_if.sv
// Core-side request/response bundle and RAM read-port signals for
// mem_rdata_router. master = core/RAM side, slave = the router.
interface mem_rdata_router_if
  import mem_rdata_router_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic              fetch_req;
  logic              load_req;
  logic [1:0]        ld_mode;
  logic              ld_hi;
  logic              mem_rd;
  logic              mem_valid;
  logic [DATA_W-1:0] ram_out;
  logic [DATA_W-1:0] ir_out;
  logic [DATA_W-1:0] rd_out;
  logic              busy;
  logic              done;
  logic              tmo_err;

  modport master (
    output fetch_req, load_req, ld_mode, ld_hi, mem_valid, ram_out,
    input  mem_rd, ir_out, rd_out, busy, done, tmo_err
  );

  modport slave (
    input  fetch_req, load_req, ld_mode, ld_hi, mem_valid, ram_out,
    output mem_rd, ir_out, rd_out, busy, done, tmo_err
  );
endinterface

// File: rtl/mem_rdata_router_ld_extend.sv
// Combinational byte select and zero/sign extension for sub-word loads.
// The byte select picks between the two low byte lanes [7:0] and [15:8].
module mem_rdata_router_ld_extend
  import mem_rdata_router_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        mode_i,
  input  logic              hi_i,
  output logic [DATA_W-1:0] data_o
);

  logic [7:0] byte_sel;

  // Pick the byte lane, then widen it according to the load mode.
  always_comb begin
    byte_sel = hi_i ? data_i[15:8] : data_i[7:0];
    data_o   = data_i;
    case (mode_i)
      LD_BU:   data_o = {{(DATA_W-8){1'b0}}, byte_sel};
      LD_BS:   data_o = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/mem_rdata_router.sv
// Registered RAM read-data router: steers RAM read data into the instruction
// register (fetch) or the read-data register (load) under a request/valid
// handshake with wait states and an optional wait-state timeout.
module mem_rdata_router
  import mem_rdata_router_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TMO_W  = 4,
  parameter bit TMO_EN = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  mem_rdata_router_if.slave bus
);

  localparam logic [TMO_W-1:0] CNT_MAX = '1;

  state_e            state_q;
  logic [TMO_W-1:0]  cnt_q;
  logic [TMO_W-1:0]  cnt_sat;
  logic [1:0]        mode_q;
  logic              hi_q;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] rd_q;
  logic              mem_rd_q;
  logic              busy_q;
  logic              done_q;
  logic              tmo_q;
  logic              tmo_hit;
  logic [DATA_W-1:0] ext_data;

  // Extension uses the mode/byte select captured when the load was accepted.
  mem_rdata_router_ld_extend #(.DATA_W(DATA_W)) u_ext (
    .data_i (bus.ram_out),
    .mode_i (mode_q),
    .hi_i   (hi_q),
    .data_o (ext_data)
  );

  // Wait counter saturates rather than wrapping. The timeout fires on the
  // wait cycle that brings the counter to all-ones, i.e. the (2**TMO_W-1)th
  // consecutive cycle without mem_valid.
  assign cnt_sat = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + TMO_W'(1);
  assign tmo_hit = TMO_EN && (cnt_sat == CNT_MAX);

  // FSM, wait counter, capture registers and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mode_q   <= LD_WORD;
      hi_q     <= 1'b0;
      ir_q     <= '0;
      rd_q     <= '0;
      mem_rd_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Fetch has priority; a simultaneous load request is dropped.
          if (bus.fetch_req) begin
            state_q  <= ST_FETCH_W;
            mem_rd_q <= 1'b1;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            tmo_q    <= 1'b0;
          end else if (bus.load_req) begin
            state_q  <= ST_LOAD_W;
            mem_rd_q <= 1'b1;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            tmo_q    <= 1'b0;
            mode_q   <= bus.ld_mode;
            hi_q     <= bus.ld_hi;
          end
        end
        ST_FETCH_W, ST_LOAD_W: begin
          // Valid data beats a timeout landing in the same cycle.
          if (bus.mem_valid) begin
            if (state_q == ST_FETCH_W) ir_q <= bus.ram_out;
            else                       rd_q <= ext_data;
            done_q   <= 1'b1;
            state_q  <= ST_IDLE;
            mem_rd_q <= 1'b0;
            busy_q   <= 1'b0;
          end else if (tmo_hit) begin
            tmo_q    <= 1'b1;
            cnt_q    <= cnt_sat;
            state_q  <= ST_IDLE;
            mem_rd_q <= 1'b0;
            busy_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_sat;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          mem_rd_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_rd  = mem_rd_q;
  assign bus.ir_out  = ir_q;
  assign bus.rd_out  = rd_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.tmo_err = tmo_q;

endmodule
